// File: rtl/alu_mdu_control.sv
// alu_mdu_control -- RV32IM execute-stage operation controller.
//
// Decodes func3/func7/decoded_instruction into a 4-bit ALU op, with an
// optionally registered output stage. M-extension ops bypass the ALU and
// are sequenced through a multi-cycle MUL/DIV unit with a start/done
// handshake, a latency down-counter and a pipeline stall.
//
// Parameters:
//   MUL_LATENCY  cycles from mdu_start to mdu_done for MUL* (func3[2]=0), >=1
//   DIV_LATENCY  cycles from mdu_start to mdu_done for DIV/REM (func3[2]=1), >=1
//   REG_OUT      1: alu_ctrl/alu_valid registered; 0: combinational
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid              instruction present in execute this cycle
//   flush                 kill current instruction / abort MDU op
//   stall_in              downstream hold; freezes outputs
//   func3, func7          instr[14:12], instr[31:25]
//   decoded_instruction   one-hot class: [8] R, [7] I-ALU, [3] B
//   alu_ctrl, alu_valid   ALU op code and its qualifier (non-M only)
//   mdu_start             1-cycle launch pulse
//   mdu_op                func3 of the M op, stable while busy
//   mdu_done              MDU result valid, held while stall_in=1
//   mdu_kill              1-cycle pulse when a busy op is flushed
//   stall_out             hold IF/ID/EX while an M op is in flight
module alu_mdu_control #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 33,
  parameter bit          REG_OUT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       flush,
  input  logic       stall_in,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic [8:0] decoded_instruction,
  output logic [3:0] alu_ctrl,
  output logic       alu_valid,
  output logic       mdu_start,
  output logic [2:0] mdu_op,
  output logic       mdu_done,
  output logic       mdu_kill,
  output logic       stall_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

  state_t     state, state_next;
  logic [5:0] cnt, cnt_next;
  logic [2:0] op_next;
  logic       is_m;
  logic [3:0] dec;

  assign is_m = decoded_instruction[8] & (func7 == 7'b0000001);

  // ALU op decode; M ops are forced to 0000 since the ALU does not own them.
  always_comb begin
    dec = '0;
    if (decoded_instruction[8] | decoded_instruction[7]) begin
      case (func3)
        3'b000: dec = (func7[5] & decoded_instruction[8]) ? 4'b0001 : 4'b0000;
        3'b001: dec = 4'b0101;
        3'b010: dec = 4'b1000;
        3'b011: dec = 4'b1001;
        3'b100: dec = 4'b0100;
        3'b101: dec = func7[5] ? 4'b0111 : 4'b0110;
        3'b110: dec = 4'b0011;
        3'b111: dec = 4'b0010;
        default: dec = '0;
      endcase
    end else if (decoded_instruction[3]) begin
      case (func3[2:1])
        2'b10:   dec = 4'b1000;
        2'b11:   dec = 4'b1001;
        default: dec = 4'b0001;
      endcase
    end
    if (is_m) dec = '0;
  end

  generate
    if (REG_OUT) begin : g_reg_out
      // Flush takes priority over stall_in so a killed op never lingers.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          alu_ctrl  <= '0;
          alu_valid <= 1'b0;
        end else if (!stall_in) begin
          alu_ctrl  <= dec;
          alu_valid <= in_valid & ~is_m;
        end
      end
    end else begin : g_comb_out
      always_comb begin
        alu_ctrl  = flush ? 4'b0000 : dec;
        alu_valid = in_valid & ~is_m & ~flush;
      end
    end
  endgenerate

  // MDU sequencer. stall_out drops on the done cycle so the M instruction
  // retires in the same cycle its result is presented.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_next    = mdu_op;
    mdu_start  = 1'b0;
    mdu_done   = 1'b0;
    mdu_kill   = 1'b0;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_m && !flush) begin
          mdu_start  = 1'b1;
          stall_out  = 1'b1;
          op_next    = func3;
          cnt_next   = func3[2] ? DIV_CNT : MUL_CNT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          mdu_kill   = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt != '0) begin
          cnt_next  = cnt - 6'd1;
          stall_out = 1'b1;
        end else begin
          mdu_done   = 1'b1;
          state_next = stall_in ? DONE : IDLE;
        end
      end
      DONE: begin
        if (flush) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          mdu_done = 1'b1;
          if (!stall_in) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mdu_op <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      mdu_op <= op_next;
    end
  end

endmodule

// File: tb/tb_alu_mdu_control.sv
module tb_alu_mdu_control;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, flush = 1'b0, stall_in = 1'b0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic [8:0] decoded_instruction = '0;
  logic [3:0] alu_ctrl;
  logic       alu_valid, mdu_start, mdu_done, mdu_kill, stall_out;
  logic [2:0] mdu_op;

  alu_mdu_control #(
    .MUL_LATENCY(MUL_LAT),
    .DIV_LATENCY(DIV_LAT),
    .REG_OUT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .stall_in(stall_in), .func3(func3), .func7(func7),
    .decoded_instruction(decoded_instruction),
    .alu_ctrl(alu_ctrl), .alu_valid(alu_valid), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_done(mdu_done), .mdu_kill(mdu_kill),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] C_R   = 9'b100000000;
  localparam logic [8:0] C_I   = 9'b010000000;
  localparam logic [8:0] C_B   = 9'b000001000;
  localparam logic [8:0] C_LD  = 9'b000000001;
  localparam logic [8:0] C_LUI = 9'b000010000;

  int checks = 0;
  int errors = 0;

  // Reference model state: op in flight, cycle its result is due, held result.
  int         cyc = 0;
  bit         m_busy = 0, m_wait = 0;
  int         m_due = 0;
  logic [2:0] m_op = '0;
  logic [3:0] m_alu = '0;
  logic       m_av = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [8:0] di, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] tbl [8];
    tbl = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    if (di[8] && f7 == 7'd1) return 4'b0000;
    if (di[8] || di[7]) begin
      if (f3 == 3'd0 && di[8] && f7[5]) return 4'b0001;   // SUB
      if (f3 == 3'd5 && f7[5]) return 4'b0111;            // SRA
      return tbl[f3];
    end
    if (di[3]) begin
      if (f3 >= 3'd6) return 4'b1001;
      if (f3 >= 3'd4) return 4'b1000;
      return 4'b0001;
    end
    return 4'b0000;
  endfunction

  task automatic step(input bit r, input bit iv, input bit fl, input bit st,
                      input logic [8:0] di, input logic [2:0] f3, input logic [6:0] f7);
    bit m, e_start, e_done, e_kill, e_stall, due_now;
    @(posedge clk);
    #1;
    rst = r; in_valid = iv; flush = fl; stall_in = st;
    decoded_instruction = di; func3 = f3; func7 = f7;
    #3;
    m       = di[8] && (f7 == 7'd1);
    due_now = m_busy && (cyc == m_due);
    e_start = !m_busy && !m_wait && iv && m && !fl;
    e_done  = !fl && (due_now || m_wait);
    e_kill  = fl && m_busy;
    e_stall = e_start || (m_busy && cyc < m_due && !fl);
    check("alu_ctrl", 32'(alu_ctrl), 32'(m_alu));
    check("alu_valid", 32'(alu_valid), 32'(m_av));
    check("mdu_op", 32'(mdu_op), 32'(m_op));
    if (!r) begin
      check("mdu_start", 32'(mdu_start), 32'(e_start));
      check("mdu_done", 32'(mdu_done), 32'(e_done));
      check("mdu_kill", 32'(mdu_kill), 32'(e_kill));
      check("stall_out", 32'(stall_out), 32'(e_stall));
    end
    if (r) begin
      m_busy = 0; m_wait = 0; m_op = '0; m_alu = '0; m_av = 1'b0;
    end else begin
      if (fl) begin
        m_busy = 0; m_wait = 0;
      end else if (e_start) begin
        m_busy = 1; m_op = f3;
        m_due  = cyc + (f3[2] ? DIV_LAT : MUL_LAT);
      end else if (due_now) begin
        m_busy = 0; m_wait = st;
      end else if (m_wait && !st) begin
        m_wait = 0;
      end
      if (fl) begin
        m_alu = '0; m_av = 1'b0;
      end else if (!st) begin
        m_alu = ref_op(di, f3, f7); m_av = iv && !m;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) step(0, 0, 0, st, C_LD, 3'd0, 7'd0);
  endtask

  initial begin
    step(1, 0, 0, 0, '0, 3'd0, 7'd0);
    step(1, 0, 0, 0, '0, 3'd0, 7'd0);
    idle(1, 0);

    // Decode examples
    step(0, 1, 0, 0, C_R,   3'b000, 7'b0100000);
    step(0, 1, 0, 0, C_I,   3'b000, 7'b0100000);
    step(0, 1, 0, 0, C_I,   3'b101, 7'b0100000);
    step(0, 1, 0, 0, C_B,   3'b110, 7'd0);
    step(0, 1, 0, 0, C_B,   3'b001, 7'd0);
    step(0, 1, 0, 0, C_LUI, 3'b011, 7'd0);
    idle(1, 0);

    // MUL, latency 2
    step(0, 1, 0, 0, C_R, 3'b000, 7'd1);
    idle(4, 0);

    // DIV flushed 10 cycles in
    step(0, 1, 0, 0, C_R, 3'b100, 7'd1);
    idle(9, 0);
    step(0, 0, 1, 0, C_LD, 3'd0, 7'd0);
    idle(40, 0);

    // DIV with downstream stall across the done window
    step(0, 1, 0, 0, C_R, 3'b110, 7'd1);
    idle(32, 0);
    idle(3, 1);
    idle(3, 0);

    // Reset mid-DIV
    step(0, 1, 0, 0, C_R, 3'b101, 7'd1);
    idle(4, 0);
    step(1, 0, 0, 0, C_LD, 3'd0, 7'd0);
    idle(3, 0);

    // Flush beats stall_in on the ALU output stage
    step(0, 1, 0, 0, C_R, 3'b111, 7'd0);
    step(0, 1, 1, 1, C_R, 3'b111, 7'd0);
    idle(2, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [8:0] di;
      logic [2:0] f3;
      logic [6:0] f7;
      int k;
      k  = int'($urandom_range(0, 5));
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      case (k)
        0: di = C_R;
        1: di = C_I;
        2: di = C_B;
        3: di = C_LD;
        4: di = C_LUI;
        default: begin di = C_R; f7 = 7'd1; end
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), di, f3, f7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
